// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared state enum and default constants for the fetch PC generator
package pc_gen_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } pc_state_e;

   // Matches the core-wide PC reset define.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;
   localparam int          DEFAULT_INC      = 4;

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-control / PC bundle between later pipeline stages and the PC generator
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] pc_plus_inc;
   logic            redirect_pending;

   modport master (
      output stall, redirect_valid, redirect_pc,
      input  pc, pc_valid, pc_plus_inc, redirect_pending
   );

   modport slave (
      input  stall, redirect_valid, redirect_pc,
      output pc, pc_valid, pc_plus_inc, redirect_pending
   );
endinterface

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - holds one redirect target that arrived while fetch was stalled
module pc_redirect_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            overwrite,
   input  logic            consume,
   input  logic [XLEN-1:0] target_in,
   output logic [XLEN-1:0] target,
   output logic            valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         target <= '0;
         valid  <= 1'b0;
      end else begin
         if (consume) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
         end
         // Latest redirect wins; a consumed entry is never rewritten.
         if ((load || overwrite) && !consume) begin
            target <= target_in;
         end
      end
   end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - fetch PC generator; define PC_ALIGN_CHECK_EN to add the sticky misalign_err output
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          INC      = DEFAULT_INC
) (
   input  logic     clk,
   input  logic     reset,
`ifdef PC_ALIGN_CHECK_EN
   output logic     misalign_err,
`endif
   pc_gen_if.slave  bus
);

   localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);
   localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

   pc_state_e       state_q, state_n;
   logic [XLEN-1:0] pc_q, pc_n;
   logic [XLEN-1:0] pc_plus;
   logic            pc_valid_q;
   logic            misaligned;
   logic            redir_ok;
   logic            buf_load, buf_overwrite, buf_consume;
   logic [XLEN-1:0] pend_target;
   logic            pend_valid;

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (bus.redirect_valid && misaligned && state_q != ST_BOOT) begin
         misalign_q <= 1'b1;
      end
   end

   assign misalign_err = misalign_q;
`else
   assign misaligned = 1'b0;
`endif

   // A misaligned redirect is dropped entirely, as if it never arrived.
   assign redir_ok = bus.redirect_valid && !misaligned;
   assign pc_plus  = pc_q + INC_X;

   always_comb begin
      state_n       = state_q;
      pc_n          = pc_q;
      buf_load      = 1'b0;
      buf_overwrite = 1'b0;
      buf_consume   = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_n = ST_RUN;
         end
         ST_RUN: begin
            if (redir_ok && !bus.stall) begin
               pc_n = bus.redirect_pc;
            end else if (redir_ok) begin
               buf_load = 1'b1;
               state_n  = ST_HOLD;
            end else if (!bus.stall) begin
               pc_n = pc_plus;
            end
         end
         ST_HOLD: begin
            if (!bus.stall) begin
               pc_n        = redir_ok ? bus.redirect_pc : pend_target;
               buf_consume = 1'b1;
               state_n     = ST_RUN;
            end else if (redir_ok) begin
               buf_overwrite = 1'b1;
            end
         end
         default: begin
            state_n = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC_X;
         pc_valid_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         pc_valid_q <= 1'b1;
      end
   end

   pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (buf_load),
      .overwrite (buf_overwrite),
      .consume   (buf_consume),
      .target_in (bus.redirect_pc),
      .target    (pend_target),
      .valid     (pend_valid)
   );

   assign bus.pc               = pc_q;
   assign bus.pc_valid         = pc_valid_q;
   assign bus.pc_plus_inc      = pc_plus;
   assign bus.redirect_pending = pend_valid;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - vector table plus scoreboard bench for pc_gen_unit (PC_ALIGN_CHECK_EN optional)
module tb_pc_gen_unit;

   localparam int XLEN = 32;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] pc;
      logic        v;
      logic        pend;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        v;
      logic [31:0] plus;
      logic        pend;
      string       tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pc_gen_if #(.XLEN(XLEN)) bus ();

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_err;
`endif

   pc_gen_unit #(
      .XLEN     (XLEN),
      .RESET_PC (32'h0000_2000),
      .INC      (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef PC_ALIGN_CHECK_EN
      .misalign_err (misalign_err),
`endif
      .bus          (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         check({e.tag, " pc"},          bus.pc,                       e.pc);
         check({e.tag, " pc_valid"},    {31'd0, bus.pc_valid},         {31'd0, e.v});
         check({e.tag, " pc_plus_inc"}, bus.pc_plus_inc,              e.plus);
         check({e.tag, " pending"},     {31'd0, bus.redirect_pending}, {31'd0, e.pend});
      end
   endtask

   task automatic step(input logic r, input logic s, input logic v, input logic [31:0] rpc,
                       input logic [31:0] epc, input logic ev, input logic epend, input string tag);
      exp_t e;
      @(negedge clk);
      reset              = r;
      bus.stall          = s;
      bus.redirect_valid = v;
      bus.redirect_pc    = rpc;
      e.pc   = epc;
      e.v    = ev;
      e.plus = epc + 32'd4;
      e.pend = epend;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   vec_t        vt[26];
   logic [31:0] m_pc;
   logic [31:0] tgt;
   int          len;

   initial begin
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      //            rst   stall rv    rpc            pc             v     pend
      vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2000, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2000, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2008, 1'b1, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_3004, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2000, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2000, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_2004, 1'b1, 1'b1};
      vt[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b1};
      vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b1};
      vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_4000, 1'b1, 1'b0};
      vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_4004, 1'b1, 1'b0};
      vt[14] = '{1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_4004, 1'b1, 1'b1};
      vt[15] = '{1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_4004, 1'b1, 1'b1};
      vt[16] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_5000, 1'b1, 1'b0};
      vt[17] = '{1'b0, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_5000, 1'b1, 1'b1};
      vt[18] = '{1'b0, 1'b0, 1'b1, 32'h0000_6000, 32'h0000_6000, 1'b1, 1'b0};
      vt[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_6000, 1'b1, 1'b0};
      vt[20] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0};
      vt[21] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b0};
      vt[22] = '{1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_0000, 1'b1, 1'b1};
      vt[23] = '{1'b1, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_2000, 1'b0, 1'b0};
      vt[24] = '{1'b0, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_2000, 1'b1, 1'b0};
      vt[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2004, 1'b1, 1'b0};

      for (int i = 0; i < 26; i++) begin
         step(vt[i].rst, vt[i].stall, vt[i].rv, vt[i].rpc,
              vt[i].pc, vt[i].v, vt[i].pend, $sformatf("row%0d", i));
      end

      // Stalled redirects of random length with random overwrites during the stall.
      m_pc = 32'h0000_2004;
      for (int t = 0; t < 4; t++) begin
         tgt = $urandom & 32'hFFFF_FFFC;
         len = $urandom_range(1, 5);
         step(1'b0, 1'b1, 1'b1, tgt, m_pc, 1'b1, 1'b1, $sformatf("hold%0d cap", t));
         for (int k = 1; k < len; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               tgt = $urandom & 32'hFFFF_FFFC;
               step(1'b0, 1'b1, 1'b1, tgt, m_pc, 1'b1, 1'b1, $sformatf("hold%0d ow%0d", t, k));
            end else begin
               step(1'b0, 1'b1, 1'b0, 32'h0, m_pc, 1'b1, 1'b1, $sformatf("hold%0d st%0d", t, k));
            end
         end
         m_pc = tgt;
         step(1'b0, 1'b0, 1'b0, 32'h0, m_pc, 1'b1, 1'b0, $sformatf("hold%0d rel", t));
         m_pc = m_pc + 32'd4;
         step(1'b0, 1'b0, 1'b0, 32'h0, m_pc, 1'b1, 1'b0, $sformatf("hold%0d inc", t));
      end

`ifdef PC_ALIGN_CHECK_EN
      check("misalign before", {31'd0, misalign_err}, 32'd0);
      m_pc = m_pc + 32'd4;
      step(1'b0, 1'b0, 1'b1, 32'h0000_3002, m_pc, 1'b1, 1'b0, "misalign drop");
      check("misalign set", {31'd0, misalign_err}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         m_pc = m_pc + 32'd4;
         step(1'b0, 1'b0, 1'b0, 32'h0, m_pc, 1'b1, 1'b0, $sformatf("misalign inc%0d", k));
         check($sformatf("misalign sticky%0d", k), {31'd0, misalign_err}, 32'd1);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_2000, 1'b0, 1'b0, "misalign reset");
      check("misalign cleared", {31'd0, misalign_err}, 32'd0);
`endif

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
